// File: rtl/ula_ctrl.sv
// ula_ctrl: four-state sequencer feeding an external ALU from an 8-entry register file.
// Optional: define ULA_CTRL_OVF_EN to build the sticky signed-overflow flag.
module ula_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] ula_a,
    output logic [DATA_W-1:0] ula_b,
    output logic [2:0]        ula_param,
    input  logic [DATA_W-1:0] ula_s,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              busy,
    output logic              ovf
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_ADDI  = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_SUBI  = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;
    localparam logic [2:0] OP_DISP  = 3'b111;

    logic [1:0]        state_q, state_d;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] a_q, b_q, b_d;
    logic [2:0]        param_q;
    logic [DATA_W-1:0] disp_data_q;
    logic              disp_valid_q;

    logic [2:0]        opc, rd, rs1, rs2;
    logic [DATA_W-1:0] imm_ext;

    assign opc     = instr_q[15:13];
    assign rd      = instr_q[12:10];
    assign rs1     = instr_q[9:7];
    assign rs2     = instr_q[6:4];
    assign imm_ext = {{(DATA_W-7){instr_q[6]}}, instr_q[6:0]};

    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign ula_a       = a_q;
    assign ula_b       = b_q;
    assign ula_param   = param_q;
    assign disp_data   = disp_data_q;
    assign disp_valid  = disp_valid_q;

    // Next state: fixed one-cycle walk through the pipeline once accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (instr_valid) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Second ALU operand: immediate, register or zero depending on opcode.
    always_comb begin
        b_d = '0;
        unique case (opc)
            OP_LOAD, OP_ADDI, OP_SUBI: b_d = imm_ext;
            OP_ADD, OP_SUB, OP_MUL:    b_d = regs_q[rs2];
            default:                   b_d = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Instruction register: loaded on the handshake only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instr_q <= '0;
        else if (instr_ready && instr_valid)
            instr_q <= instr;
    end

    // Operand registers: loaded in DECODE, held through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            param_q <= OP_LOAD;
        end else if (state_q == S_DECODE) begin
            a_q     <= regs_q[rs1];
            b_q     <= b_d;
            param_q <= opc;
        end
    end

    // Result register: captures the ALU output in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            result_q <= '0;
        else if (state_q == S_EXEC)
            result_q <= ula_s;
    end

    // Write-back: register file update or display pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            disp_valid_q <= 1'b0;
            if (state_q == S_WB) begin
                if (opc == OP_DISP) begin
                    disp_data_q  <= result_q;
                    disp_valid_q <= 1'b1;
                end else begin
                    regs_q[rd] <= result_q;
                end
            end
        end
    end

`ifdef ULA_CTRL_OVF_EN
    logic                  ovf_q;
    logic                  ovf_hit;
    logic [2*DATA_W-1:0]   prod;
    logic                  sa, sb, ss;

    assign sa = a_q[DATA_W-1];
    assign sb = b_q[DATA_W-1];
    assign ss = ula_s[DATA_W-1];

    // Signed overflow of the operation currently in EXEC.
    always_comb begin
        prod    = {{DATA_W{a_q[DATA_W-1]}}, a_q}
                * {{DATA_W{b_q[DATA_W-1]}}, b_q};
        ovf_hit = 1'b0;
        unique case (param_q)
            OP_ADD, OP_ADDI: ovf_hit = (sa == sb) && (ss != sa);
            OP_SUB, OP_SUBI: ovf_hit = (sa != sb) && (ss != sa);
            OP_MUL:          ovf_hit = (prod[2*DATA_W-1:DATA_W-1] != '0)
                                    && (prod[2*DATA_W-1:DATA_W-1] != '1);
            default:         ovf_hit = 1'b0;
        endcase
    end

    // Sticky flag: set on overflow, cleared only by CLEAR or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (state_q == S_EXEC) begin
            if (param_q == OP_CLEAR) ovf_q <= 1'b0;
            else if (ovf_hit)        ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl: random and directed instruction streams against a register-file model.
// Define ULA_CTRL_OVF_EN for both DUT and bench to check the overflow flag.
module tb_ula_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  instr = '0;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [W-1:0] ula_a, ula_b, ula_s, disp_data;
    logic [2:0]   ula_param;
    logic         disp_valid, busy, ovf;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_q[$];

    logic [W-1:0] m_regs [8];
    logic [W-1:0] m_disp;
    logic         m_ovf;

    ula_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ula_a(ula_a), .ula_b(ula_b), .ula_param(ula_param),
        .ula_s(ula_s), .disp_data(disp_data),
        .disp_valid(disp_valid), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Behavioural ALU sitting beside the controller.
    always_comb begin
        case (ula_param)
            3'b000:  ula_s = ula_b;
            3'b001,
            3'b010:  ula_s = ula_a + ula_b;
            3'b011,
            3'b100:  ula_s = ula_a - ula_b;
            3'b101:  ula_s = ula_a * ula_b;
            3'b110:  ula_s = '0;
            default: ula_s = ula_a;
        endcase
    end

    // Handshake monitor.
    always @(posedge clk) begin
        if (instr_valid && instr_ready) hs_q.push_back(cyc);
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [2:0] op, rd, rs1, rs2);
        return {op, rd, rs1, rs2, 4'b0000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [2:0] op, rd, rs1,
                                          input int imm);
        logic [6:0] i7;
        i7 = imm[6:0];
        return {op, rd, rs1, i7};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_disp = '0;
        m_ovf  = 1'b0;
    endtask

    // Issue one instruction and follow it through all four cycles.
    task automatic issue(input logic [15:0] w, input bit keep);
        logic [2:0]   op, rd, rs1, rs2;
        longint       iv, sa, sb, full, lim;
        logic [W-1:0] ext, ea, eb, res;
        bit           arith;
        int           n;
        op  = w[15:13];
        rd  = w[12:10];
        rs1 = w[9:7];
        rs2 = w[6:4];
        iv  = longint'($signed(w[6:0]));
        ext = iv[W-1:0];
        ea  = m_regs[rs1];
        case (op)
            3'd0, 3'd2, 3'd4: eb = ext;
            3'd1, 3'd3, 3'd5: eb = m_regs[rs2];
            default:          eb = '0;
        endcase
        sa    = longint'($signed(ea));
        sb    = longint'($signed(eb));
        arith = 1'b0;
        full  = 0;
        case (op)
            3'd0:       full = sb;
            3'd1, 3'd2: begin full = sa + sb; arith = 1'b1; end
            3'd3, 3'd4: begin full = sa - sb; arith = 1'b1; end
            3'd5:       begin full = sa * sb; arith = 1'b1; end
            3'd6:       full = 0;
            default:    full = sa;
        endcase
        res = full[W-1:0];
        lim = longint'(1) <<< (W - 1);

        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!keep) instr_valid = 1'b0;
        chk("busy_dec", busy, 1);
        chk("ready_dec", instr_ready, 0);
        chk("dv_dec", disp_valid, 0);
        chk("dd_hold", disp_data, m_disp);
        @(posedge clk);
        #1;
        chk("param", ula_param, op);
        chk("ula_a", ula_a, ea);
        chk("ula_b", ula_b, eb);
        chk("busy_exe", busy, 1);
        @(posedge clk);
        #1;
        chk("busy_wb", busy, 1);
        chk("ready_wb", instr_ready, 0);
        if (op == 3'd6) m_ovf = 1'b0;
`ifdef ULA_CTRL_OVF_EN
        else if (arith && (full >= lim || full < -lim)) m_ovf = 1'b1;
`endif
        @(posedge clk);
        #1;
        if (op == 3'd7) m_disp = res;
        else            m_regs[rd] = res;
        chk("ready_done", instr_ready, 1);
        chk("busy_done", busy, 0);
        chk("disp_valid", disp_valid, op == 3'd7);
        chk("disp_data", disp_data, m_disp);
        chk("ovf", ovf, m_ovf);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_a", ula_a, 0);
        chk("rst_b", ula_b, 0);
        chk("rst_param", ula_param, 0);
        chk("rst_dd", disp_data, 0);
        chk("rst_dv", disp_valid, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(enc_i(3'd0, 3'd1, 3'd0, 5), 0);
        issue(enc_i(3'd0, 3'd2, 3'd0, -3), 0);
        issue(enc_r(3'd1, 3'd3, 3'd1, 3'd2), 0);
        issue(enc_r(3'd7, 3'd0, 3'd3, 3'd0), 0);
        chk("ex1_disp", m_disp, 16'h0002);

        issue(enc_i(3'd0, 3'd1, 3'd0, 7), 0);
        issue(enc_r(3'd5, 3'd1, 3'd1, 3'd1), 0);
        issue(enc_r(3'd3, 3'd4, 3'd1, 3'd1), 0);
        issue(enc_r(3'd7, 3'd0, 3'd1, 3'd0), 0);
        chk("ex2_disp", m_disp, 16'h0031);
        issue(enc_r(3'd7, 3'd0, 3'd4, 3'd0), 0);

        issue(enc_i(3'd0, 3'd1, 3'd0, 63), 0);
        repeat (3) issue(enc_r(3'd5, 3'd1, 3'd1, 3'd1), 0);
        issue(enc_i(3'd2, 3'd2, 3'd1, 1), 0);
        issue(enc_r(3'd6, 3'd2, 3'd0, 3'd0), 0);

        hs_q.delete();
        issue(enc_i(3'd0, 3'd6, 3'd0, -64), 1);
        issue(enc_i(3'd4, 3'd6, 3'd6, 1), 1);
        issue(enc_r(3'd7, 3'd0, 3'd6, 3'd0), 0);
        repeat (3) @(negedge clk);
        chk("hs_count", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            chk("hs_gap1", hs_q[1] - hs_q[0], 4);
            chk("hs_gap2", hs_q[2] - hs_q[1], 4);
        end

        for (int k = 0; k < 60; k++) begin
            logic [15:0] w;
            w = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(w, 0);
        end

        @(negedge clk);
        instr       = enc_i(3'd0, 3'd5, 3'd0, 9);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_dv", disp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_a", ula_a, 0);
        chk("abort_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", instr_ready, 1);
        chk("abort_dv2", disp_valid, 0);
        issue(enc_r(3'd7, 3'd0, 3'd5, 3'd0), 0);
        chk("abort_r5", m_disp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ula_ctrl.md
ULA_CTRL -- requirements
Module: ula_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, datapath and register width; instruction word is fixed at 16 bits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr  input  16  instruction: [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [6:0] imm7.
REQ-005 instr_valid  input  1  instr present; transfer occurs when instr_valid and instr_ready are both high on a rising edge.
REQ-006 instr_ready  output  1  controller can accept an instruction.
REQ-007 ula_a, ula_b  output  DATA_W  operands to the ALU.
REQ-008 ula_param  output  3  ALU opcode: 000 LOAD, 001 ADD, 010 ADDI, 011 SUB, 100 SUBI, 101 MUL, 110 CLEAR, 111 DISPLAY.
REQ-009 ula_s  input  DATA_W  combinational ALU result for the current ula_a/ula_b/ula_param.
REQ-010 disp_data  output  DATA_W  value of the DISPLAY operation.
REQ-011 disp_valid  output  1  one-cycle pulse qualifying disp_data.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 ovf  output  1  sticky signed-overflow flag (see Configuration).

Function
REQ-014 Internal register file: 8 x DATA_W, signed, indices 0..7; r0 is an ordinary register.
REQ-015 FSM states IDLE -> DECODE -> EXEC -> WB -> IDLE, one cycle each; instr_ready = (state == IDLE).
REQ-016 IDLE: on handshake, latch instr into the instruction register and go to DECODE; otherwise stay.
REQ-017 DECODE: read rs1, rs2; sign-extend imm7 to DATA_W; ula_param = opcode.
REQ-018 Operand select: ula_a = reg[rs1] for all opcodes; ula_b = imm_ext for LOAD/ADDI/SUBI, reg[rs2] for ADD/SUB/MUL, 0 for CLEAR/DISPLAY.
REQ-019 ula_a/ula_b/ula_param are registered, stable from DECODE exit through end of EXEC.
REQ-020 EXEC: capture ula_s into the result register.
REQ-021 WB: opcodes 000..110 write the result into reg[rd]; DISPLAY writes no register, drives disp_data = result, pulses disp_valid for exactly this cycle.
REQ-022 disp_data holds its last value until the next DISPLAY.
REQ-023 Latency: handshake on edge N -> register write (or disp_valid) visible after edge N+3; instr_ready high again after edge N+3; throughput one instruction per 4 cycles.
REQ-024 Register write is visible to the next instruction's DECODE (no hazard; strict serialization).
REQ-025 rd == rs1 or rd == rs2: operands read old value, rd receives new value.
REQ-026 Arithmetic wraps modulo 2^DATA_W; MUL keeps the low DATA_W bits.
REQ-027 instr_valid while not ready: ignored, instr not consumed; the source holds it.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, all 8 registers 0, instruction/result registers 0, ula_a = ula_b = 0, ula_param = 000, disp_data = 0, disp_valid = 0, ovf = 0.
REQ-029 Reset mid-operation aborts the instruction with no register write and no disp_valid; instr_ready goes high on the first edge after release.

Configuration
REQ-030 Macro ULA_CTRL_OVF_EN: when defined, in EXEC ovf sets on signed overflow of ADD/ADDI (operands same sign, result sign differs), SUB/SUBI (operands differ in sign, result sign differs from ula_a), or MUL (full 2*DATA_W product not representable in DATA_W); ovf clears only on reset or CLEAR.
REQ-031 When ULA_CTRL_OVF_EN is undefined, ovf is tied to 0 and no overflow logic is synthesized.

Verification
REQ-032 LOAD r1,#5; LOAD r2,#-3; ADD r3,r1,r2; DISPLAY r3 -> disp_valid one pulse, disp_data = 0x0002.
REQ-033 LOAD r1,#7; MUL r1,r1,r1; SUB r4,r1,r1; DISPLAY r1 -> disp_data = 0x0031; r4 = 0.
REQ-034 instr_valid held high continuously with 3 instructions -> each accepted exactly once, handshakes 4 cycles apart, busy high 3 of every 4 cycles.
REQ-035 rst_n low during EXEC of LOAD r5,#9 -> r5 stays 0, no disp_valid; next DISPLAY r5 -> disp_data = 0.
REQ-036 With ULA_CTRL_OVF_EN: LOAD r1,#63; MUL r1,r1,r1 (x3 -> 63^4 = 15752961) -> ovf = 1, remains 1 until CLEAR; without macro ovf = 0 throughout.
